// File: rtl/md_pkg.sv
// Shared definitions for the multiply/divide unit: op codes, FSM states, default latencies.
package md_pkg;

  localparam logic [3:0] OP_NONE  = 4'd0;
  localparam logic [3:0] OP_MULT  = 4'd1;
  localparam logic [3:0] OP_MULTU = 4'd2;
  localparam logic [3:0] OP_DIV   = 4'd3;
  localparam logic [3:0] OP_DIVU  = 4'd4;
  localparam logic [3:0] OP_MTHI  = 4'd5;
  localparam logic [3:0] OP_MTLO  = 4'd6;
  localparam logic [3:0] OP_MFHI  = 4'd7;
  localparam logic [3:0] OP_MFLO  = 4'd8;

  localparam int MD_MULT_CYCLES = 5;
  localparam int MD_DIV_CYCLES  = 10;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } md_state_t;

  // Two's-complement negate when c is set.
  function automatic logic [31:0] neg_if(input logic c, input logic [31:0] v);
    return c ? (~v + 32'd1) : v;
  endfunction

endpackage

// File: rtl/md_calc.sv
// Combinational arithmetic core: 64-bit product plus quotient/remainder with zero-divisor flag.
module md_calc
  import md_pkg::*;
(
  input  logic [3:0]  op,
  input  logic [31:0] rs,
  input  logic [31:0] rt,
  output logic [63:0] prod,
  output logic [31:0] quot,
  output logic [31:0] rem,
  output logic        div_zero
);

  logic               is_signed;
  logic signed [63:0] a_ext;
  logic signed [63:0] b_ext;
  logic               a_neg;
  logic               b_neg;
  logic [31:0]        a_mag;
  logic [31:0]        b_mag;
  logic [31:0]        q_mag;
  logic [31:0]        r_mag;

  // Division runs on magnitudes so 0x80000000 / -1 wraps to 0x80000000 with no overflow trap.
  always_comb begin
    is_signed = (op == OP_MULT) || (op == OP_DIV);
    a_ext     = is_signed ? {{32{rs[31]}}, rs} : {32'd0, rs};
    b_ext     = is_signed ? {{32{rt[31]}}, rt} : {32'd0, rt};
    prod      = a_ext * b_ext;
    a_neg     = is_signed & rs[31];
    b_neg     = is_signed & rt[31];
    div_zero  = (rt == 32'd0);
    a_mag     = neg_if(a_neg, rs);
    b_mag     = div_zero ? 32'd1 : neg_if(b_neg, rt);
    q_mag     = a_mag / b_mag;
    r_mag     = a_mag % b_mag;
    quot      = neg_if(a_neg ^ b_neg, q_mag);
    rem       = neg_if(a_neg, r_mag);
  end

endmodule

// File: rtl/md_unit.sv
// E-stage multiply/divide unit: IDLE/BUSY sequencer, HI/LO registers, stall request and readout.
module md_unit
  import md_pkg::*;
#(
  parameter int MULT_CYCLES = MD_MULT_CYCLES,
  parameter int DIV_CYCLES  = MD_DIV_CYCLES
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [3:0]  E_mdOp,
  input  logic [31:0] E_rs,
  input  logic [31:0] E_rt,
  input  logic        D_isMd,
  output logic [31:0] md_out,
  output logic        busy,
  output logic        md_stall,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  localparam int CNT_MAX = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CNT_W   = $clog2(CNT_MAX) + 1;

  md_state_t         state;
  md_state_t         state_next;
  logic [CNT_W-1:0]  cnt;
  logic [31:0]       pend_hi;
  logic [31:0]       pend_lo;
  logic [31:0]       res_hi;
  logic [31:0]       res_lo;
  logic [63:0]       prod;
  logic [31:0]       quot;
  logic [31:0]       rem;
  logic              div_zero;
  logic              is_mul;
  logic              is_div;
  logic              start;
  logic              last;

  md_calc u_calc (
    .op       (E_mdOp),
    .rs       (E_rs),
    .rt       (E_rt),
    .prod     (prod),
    .quot     (quot),
    .rem      (rem),
    .div_zero (div_zero)
  );

  assign is_mul   = (E_mdOp == OP_MULT) || (E_mdOp == OP_MULTU);
  assign is_div   = (E_mdOp == OP_DIV)  || (E_mdOp == OP_DIVU);
  assign start    = (state == ST_IDLE) && (is_mul || is_div);
  assign busy     = (state == ST_BUSY);
  assign last     = busy && (cnt == CNT_W'(1));
  assign md_stall = D_isMd & (start | busy);

  // A zero divisor re-latches the current HI/LO so the retire leaves them untouched.
  always_comb begin
    res_hi = hi;
    res_lo = lo;
    if (is_mul) begin
      res_hi = prod[63:32];
      res_lo = prod[31:0];
    end else if (is_div && !div_zero) begin
      res_hi = rem;
      res_lo = quot;
    end
  end

  always_comb begin
    md_out = 32'd0;
    if (E_mdOp == OP_MFHI) md_out = hi;
    else if (E_mdOp == OP_MFLO) md_out = lo;
  end

  always_comb begin
    state_next = state;
    unique case (state)
      ST_IDLE: if (start) state_next = ST_BUSY;
      ST_BUSY: if (last)  state_next = ST_IDLE;
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_next;
  end

  // Any op presented while busy is ignored; only the countdown advances.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt     <= '0;
      hi      <= 32'd0;
      lo      <= 32'd0;
      pend_hi <= 32'd0;
      pend_lo <= 32'd0;
    end else if (state == ST_IDLE) begin
      if (start) begin
        pend_hi <= res_hi;
        pend_lo <= res_lo;
        cnt     <= is_mul ? CNT_W'(MULT_CYCLES) : CNT_W'(DIV_CYCLES);
      end else if (E_mdOp == OP_MTHI) begin
        hi <= E_rs;
      end else if (E_mdOp == OP_MTLO) begin
        lo <= E_rs;
      end
    end else if (last) begin
      hi  <= pend_hi;
      lo  <= pend_lo;
      cnt <= '0;
    end else begin
      cnt <= cnt - CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_md_unit.sv
// Scoreboard bench for md_unit: directed ops push expected HI/LO and reads; a monitor checks them.
module tb_md_unit;
  import md_pkg::*;

  logic        clk;
  logic        reset;
  logic [3:0]  E_mdOp;
  logic [31:0] E_rs;
  logic [31:0] E_rt;
  logic        D_isMd;
  logic [31:0] md_out;
  logic        busy;
  logic        md_stall;
  logic [31:0] hi;
  logic [31:0] lo;

  int checks = 0;
  int errors = 0;

  logic [63:0] ret_q[$];
  logic [31:0] rd_q[$];
  logic        prev_busy = 1'b0;
  logic [63:0] exp_ret;
  logic [31:0] exp_rd;

  md_unit #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
    .clk      (clk),
    .reset    (reset),
    .E_mdOp   (E_mdOp),
    .E_rs     (E_rs),
    .E_rt     (E_rt),
    .D_isMd   (D_isMd),
    .md_out   (md_out),
    .busy     (busy),
    .md_stall (md_stall),
    .hi       (hi),
    .lo       (lo)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  // Monitor: retire when busy falls, md_out on every MFHI/MFLO, no op while busy.
  always @(negedge clk) begin
    if (busy) chk("no_op_while_busy", 32'(E_mdOp), 32'(OP_NONE));
    if (prev_busy && !busy) begin
      if (ret_q.size() == 0) begin
        chk("unexpected_retire", 32'd1, 32'd0);
      end else begin
        exp_ret = ret_q.pop_front();
        chk("retire_hi", hi, exp_ret[63:32]);
        chk("retire_lo", lo, exp_ret[31:0]);
      end
    end
    if (E_mdOp == OP_MFHI || E_mdOp == OP_MFLO) begin
      if (rd_q.size() == 0) begin
        chk("unexpected_read", 32'd1, 32'd0);
      end else begin
        exp_rd = rd_q.pop_front();
        chk("md_out_read", md_out, exp_rd);
      end
    end
    prev_busy <= busy;
  end

  task automatic run_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                        input int cyc, input logic [31:0] eh, input logic [31:0] el);
    E_mdOp = op; E_rs = a; E_rt = b; D_isMd = 1'b1;
    ret_q.push_back({eh, el});
    @(negedge clk);
    chk("start_busy", 32'(busy), 32'd0);
    chk("start_stall", 32'(md_stall), 32'd1);
    chk("start_md_out", md_out, 32'd0);
    for (int i = 1; i <= cyc; i++) begin
      next_cycle();
      E_mdOp = OP_NONE; E_rs = 32'd0; E_rt = 32'd0; D_isMd = i[0];
      @(negedge clk);
      chk("busy_cycle", 32'(busy), 32'd1);
      chk("busy_stall", 32'(md_stall), 32'(D_isMd));
    end
    next_cycle();
    E_mdOp = OP_NONE; D_isMd = 1'b0;
  endtask

  task automatic read_op(input logic [3:0] op, input logic [31:0] exp);
    E_mdOp = op; D_isMd = 1'b0;
    rd_q.push_back(exp);
    @(negedge clk);
    chk("read_busy", 32'(busy), 32'd0);
    chk("read_stall", 32'(md_stall), 32'd0);
    next_cycle();
    E_mdOp = OP_NONE;
  endtask

  initial begin
    reset = 1'b1; E_mdOp = OP_NONE; E_rs = 32'd0; E_rt = 32'd0; D_isMd = 1'b1;
    next_cycle();
    next_cycle();
    @(negedge clk);
    chk("reset_hi", hi, 32'd0);
    chk("reset_lo", lo, 32'd0);
    chk("reset_busy", 32'(busy), 32'd0);
    chk("reset_stall", 32'(md_stall), 32'd0);
    chk("reset_md_out", md_out, 32'd0);
    next_cycle();
    reset = 1'b0; D_isMd = 1'b0;

    // mult then mfhi that was held in D; mfhi reaches E in cycle 6
    run_op(OP_MULT, 32'hFFFFFFFF, 32'd2, 5, 32'hFFFFFFFF, 32'hFFFFFFFE);
    read_op(OP_MFHI, 32'hFFFFFFFF);
    run_op(OP_MULTU, 32'hFFFFFFFF, 32'd2, 5, 32'h00000001, 32'hFFFFFFFE);
    read_op(OP_MFHI, 32'h00000001);
    run_op(OP_DIV, 32'hFFFFFFF9, 32'd2, 10, 32'hFFFFFFFF, 32'hFFFFFFFD);
    read_op(OP_MFLO, 32'hFFFFFFFD);
    run_op(OP_DIVU, 32'd7, 32'd2, 10, 32'd1, 32'd3);
    read_op(OP_MFHI, 32'd1);

    // MTLO then MFLO with no stall
    E_mdOp = OP_MTLO; E_rs = 32'h1234; D_isMd = 1'b1;
    @(negedge clk);
    chk("mtlo_stall", 32'(md_stall), 32'd0);
    next_cycle();
    read_op(OP_MFLO, 32'h00001234);

    // divide by zero keeps HI/LO but still takes the full latency
    E_mdOp = OP_MTHI; E_rs = 32'hAA; D_isMd = 1'b0;
    next_cycle();
    run_op(OP_DIV, 32'd5, 32'd0, 10, 32'hAA, 32'h1234);
    read_op(OP_MFHI, 32'hAA);

    run_op(OP_DIV, 32'h80000000, 32'hFFFFFFFF, 10, 32'd0, 32'h80000000);
    read_op(OP_MFLO, 32'h80000000);

    // reset in cycle 3 of a MULT aborts it
    E_mdOp = OP_MULT; E_rs = 32'd3; E_rt = 32'd4; D_isMd = 1'b1;
    ret_q.push_back(64'd0);
    next_cycle();
    E_mdOp = OP_NONE;
    next_cycle();
    next_cycle();
    reset = 1'b1;
    @(negedge clk);
    chk("abort_busy_before", 32'(busy), 32'd1);
    next_cycle();
    reset = 1'b0;
    @(negedge clk);
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_stall", 32'(md_stall), 32'd0);
    chk("abort_hi", hi, 32'd0);
    chk("abort_lo", lo, 32'd0);
    next_cycle();
    run_op(OP_MULT, 32'd3, 32'd4, 5, 32'd0, 32'd12);
    read_op(OP_MFLO, 32'd12);

    next_cycle();
    next_cycle();
    chk("ret_q_empty", 32'(ret_q.size()), 32'd0);
    chk("rd_q_empty", 32'(rd_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
